// File: rtl/rob_pkg.sv
// Shared types for the reorder-buffer commit path: entry layout, FSM states and exception codes.
package rob_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] result;
    logic [4:0]  dest_reg;
    logic        dest_we;
    logic        is_store;
    logic [3:0]  st_tag;
    logic        exc;
    logic [4:0]  exc_code;
  } rob_entry_t;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    FLUSH      = 2'd1,
    FLUSH_WAIT = 2'd2
  } commit_state_e;

  localparam logic [4:0] EXC_INSTR_MISALIGN = 5'd0;
  localparam logic [4:0] EXC_INSTR_FAULT    = 5'd1;
  localparam logic [4:0] EXC_ILLEGAL        = 5'd2;
  localparam logic [4:0] EXC_BREAKPOINT     = 5'd3;
  localparam logic [4:0] EXC_LOAD_MISALIGN  = 5'd4;
  localparam logic [4:0] EXC_LOAD_FAULT     = 5'd5;
  localparam logic [4:0] EXC_STORE_MISALIGN = 5'd6;
  localparam logic [4:0] EXC_STORE_FAULT    = 5'd7;
  localparam logic [4:0] EXC_ECALL          = 5'd11;

endpackage

// File: rtl/rob_commit_ctrl_commit_select.sv
// Lane eligibility for in-order commit: walks the head slots oldest-first and stops at the
// first lane that cannot retire (invalid, beyond the tail, excepting, or a blocked store).
module commit_select #(
  parameter int EXT_COUNT = 2,
  parameter int DEPTHLOG2 = 4,
  parameter int CNTW      = $clog2(EXT_COUNT + 1),
  parameter int LANEW     = (EXT_COUNT > 1) ? $clog2(EXT_COUNT) : 1
) (
  input  logic [EXT_COUNT-1:0] slotValid,
  input  logic [EXT_COUNT-1:0] slotExc,
  input  logic [EXT_COUNT-1:0] slotStore,
  input  logic [DEPTHLOG2-1:0] usedCount,
  input  logic                 stReady,
  output logic [EXT_COUNT-1:0] commit,
  output logic [CNTW-1:0]      consumeCount,
  output logic                 stFound,
  output logic [LANEW-1:0]     stLane,
  output logic                 excFound,
  output logic [LANEW-1:0]     excLane
);

  logic open;

  // Prefix walk: 'open' drops as soon as a lane fails, so every later lane is held back.
  // Only the first store of the cycle may go; a second store closes the window.
  always_comb begin
    commit       = '0;
    consumeCount = '0;
    stFound      = 1'b0;
    stLane       = '0;
    excFound     = 1'b0;
    excLane      = '0;
    open         = 1'b1;
    for (int i = 0; i < EXT_COUNT; i++) begin
      if (open && slotValid[i] && (i < int'(usedCount))) begin
        if (slotExc[i]) begin
          excFound = 1'b1;
          excLane  = LANEW'(i);
          open     = 1'b0;
        end else if (slotStore[i]) begin
          if (stFound) begin
            open = 1'b0;
          end else begin
            stFound = 1'b1;
            stLane  = LANEW'(i);
            if (stReady) begin
              commit[i]    = 1'b1;
              consumeCount = consumeCount + CNTW'(1);
            end else begin
              open = 1'b0;
            end
          end
        end else begin
          commit[i]    = 1'b1;
          consumeCount = consumeCount + CNTW'(1);
        end
      end else begin
        open = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rob_commit_ctrl.sv
// In-order ROB commit controller: retires up to EXT_COUNT head entries per cycle, drives the
// register-file write lanes, releases one store per cycle and sequences exception flushes.
module rob_commit_ctrl
  import rob_pkg::*;
#(
  parameter int EXT_COUNT = 2,
  parameter int DEPTH     = 16,
  parameter int DEPTHLOG2 = $clog2(DEPTH),
  parameter int CNTW      = $clog2(EXT_COUNT + 1)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [EXT_COUNT-1:0] slot_valid,
  input  rob_entry_t           slot_data [EXT_COUNT],
  input  logic [DEPTHLOG2-1:0] used_count,
  output logic [CNTW-1:0]      consume_count,
  output logic [EXT_COUNT-1:0] rf_we,
  output logic [4:0]           rf_waddr [EXT_COUNT],
  output logic [31:0]          rf_wdata [EXT_COUNT],
  output logic                 st_valid,
  input  logic                 st_ready,
  output logic [3:0]           st_slot,
  output logic                 flush,
  output logic [31:0]          flush_pc,
  output logic [4:0]           flush_code,
  input  logic                 flush_done,
  output logic [31:0]          committed_cnt
);

  localparam int LANEW = (EXT_COUNT > 1) ? $clog2(EXT_COUNT) : 1;

  commit_state_e state_q, state_d;
  logic [31:0]   flushPc_q, flushPc_d;
  logic [4:0]    flushCode_q, flushCode_d;
  logic [31:0]   committedCnt_q;

  logic [EXT_COUNT-1:0] slotExc, slotStore, selCommit;
  logic [CNTW-1:0]      selCount;
  logic                 stFound, excFound;
  logic [LANEW-1:0]     stLane, excLane;

  // Pull out just the flags the selector needs from each head entry.
  always_comb begin
    slotExc   = '0;
    slotStore = '0;
    for (int i = 0; i < EXT_COUNT; i++) begin
      slotExc[i]   = slot_data[i].exc;
      slotStore[i] = slot_data[i].is_store;
    end
  end

  commit_select #(
    .EXT_COUNT (EXT_COUNT),
    .DEPTHLOG2 (DEPTHLOG2),
    .CNTW      (CNTW),
    .LANEW     (LANEW)
  ) u_select (
    .slotValid    (slot_valid),
    .slotExc      (slotExc),
    .slotStore    (slotStore),
    .usedCount    (used_count),
    .stReady      (st_ready),
    .commit       (selCommit),
    .consumeCount (selCount),
    .stFound      (stFound),
    .stLane       (stLane),
    .excFound     (excFound),
    .excLane      (excLane)
  );

  // Next state and flush capture: an exception seen in RUN latches its PC/code and starts the flush.
  always_comb begin
    state_d     = state_q;
    flushPc_d   = flushPc_q;
    flushCode_d = flushCode_q;
    case (state_q)
      RUN: begin
        if (excFound) begin
          flushPc_d   = slot_data[excLane].pc;
          flushCode_d = slot_data[excLane].exc_code;
          state_d     = FLUSH;
        end
      end
      FLUSH:      state_d = FLUSH_WAIT;
      FLUSH_WAIT: if (flush_done) state_d = RUN;
      default:    state_d = RUN;
    endcase
  end

  // Commit-side outputs are live only in RUN; everything reads as idle while a flush is in progress.
  always_comb begin
    consume_count = '0;
    rf_we         = '0;
    st_valid      = 1'b0;
    st_slot       = '0;
    for (int i = 0; i < EXT_COUNT; i++) begin
      rf_waddr[i] = '0;
      rf_wdata[i] = '0;
    end
    if (state_q == RUN) begin
      consume_count = selCount;
      st_valid      = stFound;
      st_slot       = slot_data[stLane].st_tag;
      for (int i = 0; i < EXT_COUNT; i++) begin
        rf_we[i]    = selCommit[i] & slot_data[i].dest_we;
        rf_waddr[i] = slot_data[i].dest_reg;
        rf_wdata[i] = slot_data[i].result;
      end
    end
  end

  // State, flush record and the retired-instruction counter (wraps naturally at 2^32).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= RUN;
      flushPc_q      <= '0;
      flushCode_q    <= '0;
      committedCnt_q <= '0;
    end else begin
      state_q        <= state_d;
      flushPc_q      <= flushPc_d;
      flushCode_q    <= flushCode_d;
      committedCnt_q <= committedCnt_q + 32'(consume_count);
    end
  end

  assign flush         = (state_q == FLUSH);
  assign flush_pc      = flushPc_q;
  assign flush_code    = flushCode_q;
  assign committed_cnt = committedCnt_q;

endmodule

// File: doc/rob_commit_ctrl.md
Name: rob_commit_ctrl

Overview:
In-order commit scheduler on the extract side of the reorder buffer. Each cycle it inspects the EXT_COUNT head slots and decides how many retire (consume_count). It drives the architectural register-file write ports and releases at most one store to the store buffer. On an excepting head instruction it sequences a pipeline flush and waits for the flush to complete.

Parameters:
EXT_COUNT, 2, head slots inspected and maximum retires per cycle
DEPTH, 16, ROB depth; sets the used_count width
DEPTHLOG2, $clog2(DEPTH), ROB index width
CNTW, $clog2(EXT_COUNT+1), width of consume_count; must be able to encode EXT_COUNT

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
slot_valid[EXT_COUNT]  in  1  ROB head slot i result written
slot_data[EXT_COUNT]  in  rob_entry_t  ROB head slot i contents
used_count  in  DEPTHLOG2  occupied ROB entries
consume_count  out  CNTW  entries to retire this cycle
rf_we[EXT_COUNT]  out  1  architectural register write enable, lane i
rf_waddr[EXT_COUNT]  out  5  destination register, lane i
rf_wdata[EXT_COUNT]  out  32  result, lane i
st_valid  out  1  store commit request
st_ready  in  1  store buffer accepts this cycle
st_slot  out  DEPTHLOG2-free tag: 4-bit store-queue id from the entry
flush  out  1  one-cycle pipeline/ROB flush pulse
flush_pc  out  32  PC of the excepting instruction
flush_code  out  5  exception code
flush_done  in  1  pipeline and ROB pointers cleared
committed_cnt  out  32  retired instruction counter

Behaviour:
- Reset (async): state=RUN, flush=0, flush_pc=0, flush_code=0, committed_cnt=0. Combinational outputs evaluate to 0 while state is not RUN.
- Lane i is eligible when all of the following hold:
  - slot_valid[i]=1
  - i < used_count (guards stale valid bits beyond the tail)
  - every lane j<i is eligible and committing
  - slot_data[i].exc=0
  - if slot_data[i].is_store: no earlier lane this cycle is a store, and st_ready=1
- consume_count is the number of leading eligible lanes, 0..EXT_COUNT. It is combinational and visible in the same cycle as slot_valid (zero-latency commit decision).
- Register-file lanes: rf_we[i] = committing(i) & slot_data[i].dest_we; rf_waddr and rf_wdata are taken from the entry.
- Store lane: st_valid=1 when the first non-committed-yet lane that is valid and in range is a store with no earlier store this cycle, independent of st_ready (valid must not depend on ready). st_tag is taken from that entry.
- FSM has three states: RUN, FLUSH, FLUSH_WAIT.
- RUN: if lane k (valid, in range, all lanes <k committing) has exc=1:
  - lanes <k commit this cycle;
  - latch flush_pc=slot_data[k].pc and flush_code=slot_data[k].exc_code;
  - go to FLUSH.
  Otherwise stay in RUN.
- FLUSH: flush=1 for exactly one cycle, consume_count=0; go to FLUSH_WAIT.
- FLUSH_WAIT: consume_count=0, no rf or store activity. On flush_done=1 go to RUN; commit may resume the cycle after.
- flush_done seen in RUN or FLUSH is ignored.
- committed_cnt += consume_count every cycle; it wraps modulo 2^32.
- used_count=0 forces consume_count=0 regardless of slot_valid.
- Excepting instruction at lane 0 gives consume_count=0 that cycle; the excepting entry is never consumed by this block (the flush discards it).
- Reset asserted mid-FLUSH_WAIT returns to RUN with no flush pulse.

Decomposition:
- Package rob_pkg:
  - rob_entry_t: pc[31:0], result[31:0], dest_reg[4:0], dest_we, is_store, st_tag[3:0], exc, exc_code[4:0]
  - commit_state_e: RUN, FLUSH, FLUSH_WAIT
  - EXC_* code constants
- One natural sub-module, commit_select: the purely combinational lane-eligibility and prefix logic, outputting per-lane commit bits, consume_count, store lane index and exception lane index. The FSM, latches and counter stay in rob_commit_ctrl.

Test Plan:
- used_count=2, both valid, no store/exc, dest_we=1 on both -> consume_count=2, rf_we=2'b11, committed_cnt advances by 2.
- used_count=2, slot0 valid, slot1 valid but slot0 not valid -> consume_count=0. Then slot0 valid, slot1 not valid -> consume_count=1.
- used_count=1, both slot_valid=1 -> consume_count=1 (stale slot1 ignored).
- Two stores at lanes 0 and 1, st_ready=1 -> cycle1: consume 1, st_valid=1, st_tag=lane0. Next head cycle: consume 1. With st_ready=0 -> consume 0 and st_valid held at 1.
- Lane1 exc=1, pc=0x400, code=5 -> lane0 commits. Next cycle: flush=1 for one cycle, flush_pc=0x400, flush_code=5. consume_count stays 0 until the cycle after flush_done.
- Assert reset_n=0 during FLUSH_WAIT -> state RUN, committed_cnt=0, no flush pulse after release.
